// File: rtl/cpu_pkg.sv
// Shared CPU encodings: branch condition modes, exception cause codes and PC sequencer states.
// Also provides the branch-condition decode used by the PC unit.
package cpu_pkg;

  // Branch condition modes carried on cond_mode
  localparam logic [1:0] COND_EQ  = 2'b00;  // zero
  localparam logic [1:0] COND_NE  = 2'b01;  // !zero
  localparam logic [1:0] COND_LEZ = 2'b10;  // neg | zero
  localparam logic [1:0] COND_GTZ = 2'b11;  // !neg & !zero

  // Exception cause codes; 2'b11 is reserved
  localparam logic [1:0] CAUSE_OPC   = 2'b00;
  localparam logic [1:0] CAUSE_OVF   = 2'b01;
  localparam logic [1:0] CAUSE_ALIGN = 2'b10;

  // PC sequencer states
  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_EXC = 1'b1;

  // Historic handler entry; accepted as an exception vector despite its low bits
  localparam logic [31:0] LEGACY_EXC_VECTOR = 32'h0000_00FF;

  typedef logic [1:0] cause_t;
  typedef logic [1:0] cond_mode_t;

  function automatic logic cond_eval(input cond_mode_t mode, input logic zero, input logic neg);
    logic ok;
    ok = 1'b0;
    case (mode)
      COND_EQ:  ok = zero;
      COND_NE:  ok = ~zero;
      COND_LEZ: ok = neg | zero;
      COND_GTZ: ok = ~neg & ~zero;
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mux_n_to_1.sv
// Parametrised N-way mux over a flattened source bus.
// Out-of-range selects fall through to the last source.
module mux_n_to_1 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NSRC  = 6,
  parameter int unsigned SEL_W = $clog2(NSRC)
) (
  input  logic [NSRC*WIDTH-1:0] src_flat,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      dout
);

  if (NSRC < 2) begin : g_bad_nsrc
    $error("mux_n_to_1: NSRC must be at least 2");
  end

  always_comb begin
    dout = src_flat[(NSRC-1)*WIDTH +: WIDTH];
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (sel == SEL_W'(i)) begin
        dout = src_flat[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter unit: next-PC source mux, PC register, branch write enable,
// misalignment detection and a two-state exception sequencer (EPC/cause, vector redirect).
module pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     WIDTH      = 32,
  parameter int unsigned     NSRC       = 6,
  parameter int unsigned     SEL_W      = $clog2(NSRC),
  parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_00FF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSRC*WIDTH-1:0] src_flat,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  pc_write,
  input  logic                  pc_write_cond,
  input  logic [1:0]            cond_mode,
  input  logic                  zero,
  input  logic                  neg,
  input  logic                  exc_req,
  input  logic [1:0]            exc_cause,
  output logic [WIDTH-1:0]      next_pc,
  output logic [WIDTH-1:0]      pc,
  output logic [WIDTH-1:0]      epc,
  output logic [1:0]            cause,
  output logic                  busy
);

  if (WIDTH < 2) begin : g_bad_width
    $error("pc_unit: WIDTH must be at least 2");
  end
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("pc_unit: RESET_PC must be word-aligned");
  end
  // The legacy 0xFF handler entry is loaded directly by the sequencer and is tolerated
  if ((EXC_VECTOR[1:0] != 2'b00) && (EXC_VECTOR != WIDTH'(LEGACY_EXC_VECTOR)))
  begin : g_bad_exc_vector
    $error("pc_unit: EXC_VECTOR must be word-aligned");
  end

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  cause_t           cause_q, cause_d;

  logic cond_ok;
  logic we;
  logic misaligned;

  mux_n_to_1 #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC),
    .SEL_W (SEL_W)
  ) u_src_mux (
    .src_flat (src_flat),
    .sel      (sel),
    .dout     (next_pc)
  );

  assign cond_ok    = cond_eval(cond_mode, zero, neg);
  assign we         = pc_write | (pc_write_cond & cond_ok);
  assign misaligned = we & (next_pc[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    case (state_q)
      ST_RUN: begin
        // Exception entry freezes pc; the pending write is suppressed, not deferred
        if (exc_req) begin
          epc_d   = pc_q;
          cause_d = exc_cause;
          state_d = ST_EXC;
        end else if (misaligned) begin
          epc_d   = pc_q;
          cause_d = CAUSE_ALIGN;
          state_d = ST_EXC;
        end else if (we) begin
          pc_d = next_pc;
        end
      end
      ST_EXC: begin
        // Requests arriving here are dropped
        pc_d    = EXC_VECTOR;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  assign pc    = pc_q;
  assign epc   = epc_q;
  assign cause = cause_q;
  assign busy  = (state_q == ST_EXC);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios followed by random stimulus,
// all compared against a behavioural model of the PC/exception rules.
module tb_pc_unit;

  localparam int unsigned W    = 32;
  localparam int unsigned N    = 6;
  localparam int unsigned SW   = 3;
  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam logic [31:0] EVEC = 32'h0000_00FF;

  logic          clk;
  logic          reset;
  logic [N*W-1:0] src_flat;
  logic [SW-1:0] sel;
  logic          pc_write, pc_write_cond, zero, neg, exc_req;
  logic [1:0]    cond_mode, exc_cause;
  logic [W-1:0]  next_pc, pc, epc;
  logic [1:0]    cause;
  logic          busy;

  logic [31:0] srcs [N];

  always_comb begin
    src_flat = '0;
    for (int i = 0; i < N; i++) src_flat[i*W +: W] = srcs[i];
  end

  pc_unit #(
    .WIDTH      (W),
    .NSRC       (N),
    .SEL_W      (SW),
    .RESET_PC   (RPC),
    .EXC_VECTOR (EVEC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .src_flat      (src_flat),
    .sel           (sel),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .cond_mode     (cond_mode),
    .zero          (zero),
    .neg           (neg),
    .exc_req       (exc_req),
    .exc_cause     (exc_cause),
    .next_pc       (next_pc),
    .pc            (pc),
    .epc           (epc),
    .cause         (cause),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_epc;
  logic [1:0]  m_cause;
  logic        m_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_mux(input int s);
    return (s >= N) ? srcs[N-1] : srcs[s];
  endfunction

  function automatic bit model_cond(input logic [1:0] m, input logic z, input logic n);
    case (m)
      2'd0:    return z == 1'b1;
      2'd1:    return z == 1'b0;
      2'd2:    return (n == 1'b1) || (z == 1'b1);
      default: return (n == 1'b0) && (z == 1'b0);
    endcase
  endfunction

  task automatic model_reset();
    m_pc = RPC; m_epc = 0; m_cause = 0; m_busy = 0;
  endtask

  task automatic model_edge();
    bit          w;
    logic [31:0] np;
    np = model_mux(int'(sel));
    w  = pc_write || (pc_write_cond && model_cond(cond_mode, zero, neg));
    if (m_busy) begin
      m_pc = EVEC; m_busy = 0;
    end else if (exc_req) begin
      m_epc = m_pc; m_cause = exc_cause; m_busy = 1;
    end else if (w && (np % 4 != 0)) begin
      m_epc = m_pc; m_cause = 2; m_busy = 1;
    end else if (w) begin
      m_pc = np;
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".pc"},    pc,          m_pc);
    chk({tag, ".epc"},   epc,         m_epc);
    chk({tag, ".cause"}, 32'(cause),  32'(m_cause));
    chk({tag, ".busy"},  32'(busy),   32'(m_busy));
  endtask

  task automatic drive(input int s, input bit pw, input bit pwc, input int cm, input bit z,
                       input bit n, input bit er, input int ec);
    sel = SW'(s); pc_write = pw; pc_write_cond = pwc; cond_mode = 2'(cm);
    zero = z; neg = n; exc_req = er; exc_cause = 2'(ec);
  endtask

  // Inputs are set at the negedge; check mux, take the edge, check registers
  task automatic step(input string tag);
    #1;
    chk({tag, ".next_pc"}, next_pc, model_mux(int'(sel)));
    @(posedge clk);
    model_edge();
    #1;
    chk_state(tag);
    @(negedge clk);
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk_state(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    srcs[0] = 32'h4;   srcs[1] = 32'h8;   srcs[2] = 32'h100;
    srcs[3] = 32'h200; srcs[4] = 32'h300; srcs[5] = 32'h400;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset takes effect before any clock edge
    #2 reset = 1'b1;
    model_reset();
    #1 chk_state("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    drive(0, 1, 0, 0, 0, 0, 0, 0); step("write_src0");
    chk("pc_is_4", pc, 32'h4);
    drive(7, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("sel7_fallthrough", next_pc, 32'h400);
    step("sel7_hold");

    drive(1, 0, 1, 0, 0, 0, 0, 0); step("beq_not_taken");
    drive(1, 0, 1, 0, 1, 0, 0, 0); step("beq_taken");
    chk("beq_pc", pc, 32'h8);
    drive(2, 0, 1, 3, 0, 1, 0, 0); step("bgtz_neg");
    drive(2, 0, 1, 3, 0, 0, 0, 0); step("bgtz_taken");
    chk("bgtz_pc", pc, 32'h100);
    drive(3, 0, 1, 1, 1, 0, 0, 0); step("bne_not_taken");
    drive(4, 0, 1, 2, 0, 1, 0, 0); step("blez_neg");

    // Misaligned target
    srcs[0] = 32'h10; srcs[3] = 32'h102;
    drive(0, 1, 0, 0, 0, 0, 0, 0); step("to_0x10");
    drive(3, 1, 0, 0, 0, 0, 0, 0); step("misalign");
    chk("misalign_cause", 32'(cause), 32'h2);
    drive(0, 0, 0, 0, 0, 0, 0, 0); step("misalign_vec");
    chk("misalign_vec_pc", pc, EVEC);

    // Exception and write in the same cycle
    srcs[0] = 32'h40;
    drive(0, 1, 0, 0, 0, 0, 0, 0); step("to_0x40");
    drive(0, 1, 0, 0, 0, 0, 1, 1); step("collide");
    chk("collide_epc", epc, 32'h40);
    drive(0, 0, 0, 0, 0, 0, 0, 0); step("collide_vec");

    // Requests during EXC are dropped
    drive(1, 0, 0, 0, 0, 0, 1, 0); step("exc_enter");
    drive(1, 1, 0, 0, 0, 0, 1, 3); step("exc_drop");
    chk("exc_drop_cause", 32'(cause), 32'h0);
    drive(1, 0, 0, 0, 0, 0, 0, 0); step("exc_after");

    // Async reset while busy
    drive(0, 0, 0, 0, 0, 0, 1, 1); step("exc_for_reset");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    async_reset("reset_in_exc");

    // Random phase
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        srcs[k] = $urandom;
        if ($urandom_range(0, 7) != 0) srcs[k][1:0] = 2'b00;
      end
      drive(int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            ($urandom_range(0, 11) == 0), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 59) == 0) async_reset($sformatf("rnd_reset%0d", i));
      else step($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
